yurut_denetim: RTL and testbench

- Execute-stage sequencer. Accepts one decoded op per handshake and steers it to the ALU (1 cycle), multiplier (CARPMA_GECIKME cycles), iterative divider (BOLME_DONGU steps) or memory unit (BIB, variable latency).
- Drives DDB readiness, datapath strobes, writeback valid and writeback source select.
- Sits between the decode/register-read stage and writeback, beside the existing yurut datapath.

---
 rtl/yurut_denetim_pkg.sv | 34 +++
 rtl/yurut_denetim_gecikme_sayaci.sv | 53 +++++
 rtl/yurut_denetim.sv | 151 +++++++++++++++
 tb/tb_yurut_denetim.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/yurut_denetim_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : yurut_denetim_pkg                                      |
// | Description : Shared definitions for the execute-stage sequencer:    |
// |               functional-unit codes, FSM state encodings and a       |
// |               helper that identifies single-cycle operations.        |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package yurut_denetim_pkg;

  // Functional-unit codes (also the writeback mux select encoding)
  localparam logic [1:0] BIRIM_AMB    = 2'd0;
  localparam logic [1:0] BIRIM_CARPMA = 2'd1;
  localparam logic [1:0] BIRIM_BOLME  = 2'd2;
  localparam logic [1:0] BIRIM_BELLEK = 2'd3;

  // Sequencer states
  localparam logic [1:0] BOSTA  = 2'd0;
  localparam logic [1:0] CARPMA = 2'd1;
  localparam logic [1:0] BOLME  = 2'd2;
  localparam logic [1:0] BELLEK = 2'd3;

  // An op finishes in the cycle after accept without leaving BOSTA when it
  // is an ALU op, a divide by zero, or a multiply on a 1-cycle multiplier.
  function automatic logic tek_cevrim(input logic [1:0] birim,
                                      input logic       bolen_sifir,
                                      input logic       carpma_tek);
    return (birim == BIRIM_AMB) ||
           ((birim == BIRIM_BOLME) && bolen_sifir) ||
           ((birim == BIRIM_CARPMA) && carpma_tek);
  endfunction

endpackage
`default_nettype wire

// File: rtl/yurut_denetim_gecikme_sayaci.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : gecikme_sayaci                                         |
// | Description : Loadable saturating down-counter used to time the      |
// |               multiplier latency and the divider iterations.         |
// | Ports       : clk_i, rst_i   clock / sync active-high reset          |
// |               yukle_i        load deger_i                            |
// |               deger_i        load value                              |
// |               etkin_i        count enable (decrement)                |
// |               temizle_i      clear to zero (highest priority)        |
// |               sifir_o        counter currently zero                  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module gecikme_sayaci #(
  parameter int SAYAC_BIT = 6
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 yukle_i,
  input  logic [SAYAC_BIT-1:0] deger_i,
  input  logic                 etkin_i,
  input  logic                 temizle_i,
  output logic                 sifir_o
);

  localparam logic [SAYAC_BIT-1:0] c_bir = SAYAC_BIT'(1);

  logic [SAYAC_BIT-1:0] sayac_q, sayac_d;

  always_comb begin
    sayac_d = sayac_q;
    if (temizle_i) begin
      sayac_d = '0;
    end else if (yukle_i) begin
      sayac_d = deger_i;
    end else if (etkin_i && (sayac_q != '0)) begin
      // Saturates at zero: never wraps
      sayac_d = sayac_q - c_bir;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sayac_q <= '0;
    end else begin
      sayac_q <= sayac_d;
    end
  end

  assign sifir_o = (sayac_q == '0);

endmodule
`default_nettype wire

// File: rtl/yurut_denetim.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : yurut_denetim                                          |
// | Description : Execute-stage sequencer. Accepts one decoded op per    |
// |               handshake and steers it to ALU, multiplier, iterative  |
// |               divider or memory unit; drives readiness, datapath     |
// |               strobes and writeback valid / source select.           |
// | Ports       : clk_i, rst_i        clock / sync active-high reset     |
// |               cyo_gecerli_i       decode offers an op                |
// |               cyo_birim_i         target unit code                   |
// |               cyo_bolen_sifir_i   divisor is zero                    |
// |               ddb_durdur_i        downstream stall                   |
// |               ddb_bosalt_i        flush in-flight op                 |
// |               ddb_hazir_o         ready to accept                    |
// |               yurut_kaydet_o      accept strobe                      |
// |               bolme_adim_o        divider iterate enable             |
// |               bib_sec_o           memory request active              |
// |               bib_durdur_i        memory busy                        |
// |               gy_gecerli_o        writeback valid                    |
// |               gy_birim_o          writeback source select            |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module yurut_denetim
  import yurut_denetim_pkg::*;
#(
  parameter int CARPMA_GECIKME = 2,
  parameter int BOLME_DONGU    = 32,
  parameter int SAYAC_BIT      = 6
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cyo_gecerli_i,
  input  logic [1:0] cyo_birim_i,
  input  logic       cyo_bolen_sifir_i,
  input  logic       ddb_durdur_i,
  input  logic       ddb_bosalt_i,
  output logic       ddb_hazir_o,
  output logic       yurut_kaydet_o,
  output logic       bolme_adim_o,
  output logic       bib_sec_o,
  input  logic       bib_durdur_i,
  output logic       gy_gecerli_o,
  output logic [1:0] gy_birim_o
);

  // The counter exits on the cycle it is zero, so a state that must last
  // K cycles is loaded with K-1. CARPMA lasts L-1 cycles, BOLME N cycles.
  localparam int                   c_mul_yuk_int = (CARPMA_GECIKME >= 2) ? (CARPMA_GECIKME - 2) : 0;
  localparam logic [SAYAC_BIT-1:0] c_mul_yuk     = SAYAC_BIT'(c_mul_yuk_int);
  localparam logic [SAYAC_BIT-1:0] c_div_yuk     = SAYAC_BIT'(BOLME_DONGU - 1);
  localparam logic                 c_carpma_tek  = (CARPMA_GECIKME < 2);

  logic [1:0] durum_q, durum_d;
  logic       gy_gecerli_q, gy_gecerli_d;
  logic [1:0] gy_birim_q, gy_birim_d;
  logic       iptal_q, iptal_d;

  logic                 w_kabul;
  logic                 w_tamam;
  logic                 w_sayac_yukle;
  logic [SAYAC_BIT-1:0] w_yuk_deger;
  logic                 w_sayac_sifir;

  assign ddb_hazir_o    = (durum_q == BOSTA) & ~ddb_durdur_i & ~rst_i;
  assign w_kabul        = cyo_gecerli_i & ddb_hazir_o & ~ddb_bosalt_i;
  assign yurut_kaydet_o = w_kabul;

  assign w_sayac_yukle = w_kabul &
                         (((cyo_birim_i == BIRIM_CARPMA) & ~c_carpma_tek) |
                          ((cyo_birim_i == BIRIM_BOLME) & ~cyo_bolen_sifir_i));
  assign w_yuk_deger   = (cyo_birim_i == BIRIM_BOLME) ? c_div_yuk : c_mul_yuk;

  gecikme_sayaci #(
    .SAYAC_BIT (SAYAC_BIT)
  ) u_gecikme_sayaci (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .yukle_i   (w_sayac_yukle),
    .deger_i   (w_yuk_deger),
    .etkin_i   (~ddb_durdur_i),
    .temizle_i (ddb_bosalt_i),
    .sifir_o   (w_sayac_sifir)
  );

  always_comb begin
    durum_d    = durum_q;
    iptal_d    = iptal_q;
    w_tamam    = 1'b0;
    gy_birim_d = w_kabul ? cyo_birim_i : gy_birim_q;

    case (durum_q)
      BOSTA: begin
        if (w_kabul) begin
          if (tek_cevrim(cyo_birim_i, cyo_bolen_sifir_i, c_carpma_tek)) begin
            w_tamam = 1'b1;
          end else if (cyo_birim_i == BIRIM_CARPMA) begin
            durum_d = CARPMA;
          end else if (cyo_birim_i == BIRIM_BOLME) begin
            durum_d = BOLME;
          end else begin
            durum_d = BELLEK;
          end
        end
      end
      CARPMA, BOLME: begin
        if (ddb_bosalt_i) begin
          durum_d = BOSTA;
        end else if (!ddb_durdur_i && w_sayac_sifir) begin
          durum_d = BOSTA;
          w_tamam = 1'b1;
        end
      end
      default: begin
        // The bus transfer cannot be aborted; a flush only marks the
        // result to be dropped once the transfer ends.
        if (ddb_bosalt_i) begin
          iptal_d = 1'b1;
        end
        if (!bib_durdur_i) begin
          durum_d = BOSTA;
          iptal_d = 1'b0;
          w_tamam = ~(iptal_q | ddb_bosalt_i);
        end
      end
    endcase

    // Result is held while downstream stalls; a flush drops it.
    gy_gecerli_d = ddb_bosalt_i ? 1'b0 : (w_tamam | (gy_gecerli_q & ddb_durdur_i));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      durum_q      <= BOSTA;
      gy_gecerli_q <= 1'b0;
      gy_birim_q   <= BIRIM_AMB;
      iptal_q      <= 1'b0;
    end else begin
      durum_q      <= durum_d;
      gy_gecerli_q <= gy_gecerli_d;
      gy_birim_q   <= gy_birim_d;
      iptal_q      <= iptal_d;
    end
  end

  assign bolme_adim_o = (durum_q == BOLME) & ~ddb_durdur_i & ~ddb_bosalt_i;
  assign bib_sec_o    = (durum_q == BELLEK);
  assign gy_gecerli_o = gy_gecerli_q;
  assign gy_birim_o   = gy_birim_q;

endmodule
`default_nettype wire

// File: tb/tb_yurut_denetim.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_yurut_denetim                                       |
// | Description : Self-checking bench for yurut_denetim: a table of      |
// |               single ops, hand-written stall/flush/reset sequences,  |
// |               and a scoreboard of expected writeback pulses.         |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_yurut_denetim;

  localparam int L = 2;
  localparam int N = 32;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       cyo_gecerli_i;
  logic [1:0] cyo_birim_i;
  logic       cyo_bolen_sifir_i;
  logic       ddb_durdur_i;
  logic       ddb_bosalt_i;
  logic       ddb_hazir_o;
  logic       yurut_kaydet_o;
  logic       bolme_adim_o;
  logic       bib_sec_o;
  logic       bib_durdur_i;
  logic       gy_gecerli_o;
  logic [1:0] gy_birim_o;

  yurut_denetim #(
    .CARPMA_GECIKME (L),
    .BOLME_DONGU    (N),
    .SAYAC_BIT      (6)
  ) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .cyo_gecerli_i     (cyo_gecerli_i),
    .cyo_birim_i       (cyo_birim_i),
    .cyo_bolen_sifir_i (cyo_bolen_sifir_i),
    .ddb_durdur_i      (ddb_durdur_i),
    .ddb_bosalt_i      (ddb_bosalt_i),
    .ddb_hazir_o       (ddb_hazir_o),
    .yurut_kaydet_o    (yurut_kaydet_o),
    .bolme_adim_o      (bolme_adim_o),
    .bib_sec_o         (bib_sec_o),
    .bib_durdur_i      (bib_durdur_i),
    .gy_gecerli_o      (gy_gecerli_o),
    .gy_birim_o        (gy_birim_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Scoreboard of expected writeback pulses: cycle and source unit
  typedef struct {
    int         cyc;
    logic [1:0] birim;
  } sb_t;
  sb_t sb[$];

  logic prev_gy = 1'b0;
  logic prev_dur = 1'b0;

  // A pulse is new unless it is the held continuation of a stalled result.
  always @(negedge clk_i) begin
    if (rst_i) begin
      prev_gy  = 1'b0;
      prev_dur = 1'b0;
    end else begin
      if (gy_gecerli_o && !(prev_gy && prev_dur)) begin
        if (sb.size() == 0) begin
          chk("gy_unexpected", 1, 0);
        end else begin
          sb_t e;
          e = sb.pop_front();
          chk("gy_cycle", cyc, e.cyc);
          chk("gy_birim", gy_birim_o, e.birim);
        end
      end
      prev_gy  = gy_gecerli_o;
      prev_dur = ddb_durdur_i;
    end
  end

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input int lat, input logic [1:0] b);
    sb_t e;
    e.cyc   = cyc + lat;
    e.birim = b;
    sb.push_back(e);
  endtask

  // Offer one op in the current cycle and walk it until the cycle in which
  // its result appears (returning there so the next op can issue at once).
  task automatic run_op(input logic [1:0] b, input logic z, input int bekle, input int lat);
    cyo_gecerli_i     = 1'b1;
    cyo_birim_i       = b;
    cyo_bolen_sifir_i = z;
    push(lat, b);
    @(negedge clk_i);
    chk("hazir_accept", ddb_hazir_o, 1);
    chk("kaydet", yurut_kaydet_o, 1);
    next_cycle();
    cyo_gecerli_i = 1'b0;
    for (int k = 1; k < lat; k++) begin
      bib_durdur_i = (k <= bekle);
      @(negedge clk_i);
      chk("hazir_busy", ddb_hazir_o, 0);
      chk("bolme_adim", bolme_adim_o, (b == 2'd2 && !z));
      chk("bib_sec", bib_sec_o, (b == 2'd3));
      next_cycle();
    end
    bib_durdur_i = 1'b0;
  endtask

  typedef struct {
    logic [1:0] birim;
    logic       sifir;
    int         bekle;
    int         lat;
  } vec_t;

  vec_t tbl[8];

  initial begin
    tbl[0] = '{2'd0, 1'b0, 0, 1};       // ALU
    tbl[1] = '{2'd1, 1'b0, 0, L};       // MUL
    tbl[2] = '{2'd2, 1'b1, 0, 1};       // DIV by zero, accepted right after MUL
    tbl[3] = '{2'd2, 1'b0, 0, N + 1};   // DIV
    tbl[4] = '{2'd3, 1'b0, 0, 2};       // MEM, no wait
    tbl[5] = '{2'd3, 1'b0, 3, 5};       // MEM, 3 busy cycles
    tbl[6] = '{2'd0, 1'b0, 0, 1};       // ALU
    tbl[7] = '{2'd0, 1'b0, 0, 1};       // ALU back-to-back

    rst_i = 1'b1;
    cyo_gecerli_i = 1'b0;
    cyo_birim_i = 2'd0;
    cyo_bolen_sifir_i = 1'b0;
    ddb_durdur_i = 1'b0;
    ddb_bosalt_i = 1'b0;
    bib_durdur_i = 1'b0;

    // Reset
    next_cycle();
    @(negedge clk_i);
    chk("hazir_in_reset", ddb_hazir_o, 0);
    next_cycle();
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("rst_hazir", ddb_hazir_o, 1);
    chk("rst_gy", gy_gecerli_o, 0);
    chk("rst_gy_birim", gy_birim_o, 0);
    chk("rst_bib_sec", bib_sec_o, 0);
    chk("rst_bolme_adim", bolme_adim_o, 0);
    next_cycle();

    // Single-op table
    for (int i = 0; i < 8; i++) begin
      run_op(tbl[i].birim, tbl[i].sifir, tbl[i].bekle, tbl[i].lat);
    end
    next_cycle();

    // DIV with a 5-cycle stall at t=10, result stalled at t=38 for 2 cycles
    cyo_gecerli_i = 1'b1;
    cyo_birim_i = 2'd2;
    cyo_bolen_sifir_i = 1'b0;
    push(38, 2'd2);
    next_cycle();
    cyo_gecerli_i = 1'b0;
    for (int k = 1; k <= 41; k++) begin
      ddb_durdur_i = ((k >= 10) && (k <= 14)) || (k == 38) || (k == 39);
      @(negedge clk_i);
      chk("stl_adim", bolme_adim_o, (k <= 37) && !ddb_durdur_i);
      chk("stl_gy", gy_gecerli_o, (k >= 38) && (k <= 40));
      chk("stl_hazir", ddb_hazir_o, (k >= 40));
      next_cycle();
    end
    ddb_durdur_i = 1'b0;

    // Flush during DIV at t=5
    cyo_gecerli_i = 1'b1;
    cyo_birim_i = 2'd2;
    next_cycle();
    cyo_gecerli_i = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      ddb_bosalt_i = (k == 5);
      @(negedge clk_i);
      if (k == 5) chk("fl_div_adim", bolme_adim_o, 0);
      if (k >= 6) chk("fl_div_hazir", ddb_hazir_o, 1);
      chk("fl_div_gy", gy_gecerli_o, 0);
      next_cycle();
    end
    ddb_bosalt_i = 1'b0;

    // Flush during a busy MEM transfer
    cyo_gecerli_i = 1'b1;
    cyo_birim_i = 2'd3;
    next_cycle();
    cyo_gecerli_i = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      ddb_bosalt_i = (k == 2);
      bib_durdur_i = (k <= 4);
      @(negedge clk_i);
      chk("fl_mem_bib_sec", bib_sec_o, (k <= 5));
      chk("fl_mem_hazir", ddb_hazir_o, (k >= 6));
      chk("fl_mem_gy", gy_gecerli_o, 0);
      next_cycle();
    end
    ddb_bosalt_i = 1'b0;
    bib_durdur_i = 1'b0;

    // Reset in the middle of a MUL
    cyo_gecerli_i = 1'b1;
    cyo_birim_i = 2'd1;
    next_cycle();
    cyo_gecerli_i = 1'b0;
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("mr_hazir_rst", ddb_hazir_o, 0);
    next_cycle();
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("mr_gy", gy_gecerli_o, 0);
    chk("mr_gy_birim", gy_birim_o, 0);
    chk("mr_bib_sec", bib_sec_o, 0);
    chk("mr_adim", bolme_adim_o, 0);
    chk("mr_hazir", ddb_hazir_o, 1);
    repeat (4) next_cycle();

    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
